// File: rtl/cnn_window_gen.sv
// Sliding-window generator: turns a raster-order pixel stream of one image into
// every valid KxK window, packed for the simpleCNN IMGIN port, with its position.
module cnn_window_gen #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned K     = 5,
    parameter int unsigned PW    = 8,
    localparam int unsigned XW   = $clog2(IMG_W),
    localparam int unsigned YW   = $clog2(IMG_H),
    localparam int unsigned WINW = K * K * PW
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            START,
    input  logic [PW-1:0]   PIX_IN,
    input  logic            PIX_VALID,
    output logic            PIX_READY,
    output logic [WINW-1:0] WIN,
    output logic            WIN_VALID,
    input  logic            WIN_READY,
    output logic [XW-1:0]   WX,
    output logic [YW-1:0]   WY,
    output logic            BUSY,
    output logic            FRAME_DONE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [XW-1:0] col;
    logic [YW-1:0] row;

    logic accept;
    logic hshake;
    logic in_win;
    logic last_pix;
    logic load_win;

    // Line buffers: lb[i][x] holds pixel(row-(K-1)+i, x) for the row being received.
    logic [PW-1:0] lb      [K-1][IMG_W];
    // Shift window; column K-1 is the most recently accepted column.
    logic [PW-1:0] win_r   [K][K];
    logic [PW-1:0] win_nxt [K][K];
    logic [PW-1:0] colv    [K];
    logic [WINW-1:0] win_pack;

    assign accept   = PIX_VALID & PIX_READY;
    assign hshake   = WIN_VALID & WIN_READY;
    assign in_win   = (row >= YW'(K - 1)) && (col >= XW'(K - 1));
    assign last_pix = (row == YW'(IMG_H - 1)) && (col == XW'(IMG_W - 1));
    assign load_win = accept & in_win;

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; START only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = S_RUN;
            S_RUN:   if (accept && last_pix) state_nxt = S_DRAIN;
            S_DRAIN: if (hshake) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs; pixels stall while a window waits in the output register.
    always_comb begin
        PIX_READY = 1'b0;
        BUSY      = 1'b0;
        case (state)
            S_RUN: begin
                PIX_READY = ~WIN_VALID | WIN_READY;
                BUSY      = 1'b1;
            end
            S_DRAIN: begin
                BUSY      = 1'b1;
            end
            default: begin
                PIX_READY = 1'b0;
                BUSY      = 1'b0;
            end
        endcase
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            col <= '0;
            row <= '0;
        end else if (state == S_IDLE && START) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == XW'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == YW'(IMG_H - 1)) ? '0 : row + YW'(1);
            end else begin
                col <= col + XW'(1);
            end
        end
    end

    // Incoming column: K-1 buffered rows above plus the new pixel at the bottom.
    always_comb begin
        for (int unsigned r = 0; r < K - 1; r++) begin
            colv[r] = lb[r][col];
        end
        colv[K-1] = PIX_IN;
    end

    // Window after shifting the incoming column in on the right.
    always_comb begin
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
                win_nxt[r][c] = win_r[r][c+1];
            end
            win_nxt[r][K-1] = colv[r];
        end
    end

    // Pack window rows top-down, columns left-to-right, byte r*K+c.
    always_comb begin
        win_pack = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                win_pack[PW*(r*K+c) +: PW] = win_nxt[r][c];
            end
        end
    end

    // Line-buffer column shift and window shift on every accepted pixel (not reset).
    always_ff @(posedge CLK) begin
        if (accept) begin
            for (int unsigned i = 0; i + 1 < K - 1; i++) begin
                lb[i][col] <= lb[i+1][col];
            end
            lb[K-2][col] <= PIX_IN;
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c < K; c++) begin
                    win_r[r][c] <= win_nxt[r][c];
                end
            end
        end
    end

    // Single-entry output register; held while the consumer stalls.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            WIN       <= '0;
            WX        <= '0;
            WY        <= '0;
            WIN_VALID <= 1'b0;
        end else if (load_win) begin
            WIN       <= win_pack;
            WX        <= col - XW'(K - 1);
            WY        <= row - YW'(K - 1);
            WIN_VALID <= 1'b1;
        end else if (hshake) begin
            WIN_VALID <= 1'b0;
        end
    end

    // One-cycle pulse following the handshake of the frame's last window.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= (state == S_DRAIN) && hshake;
        end
    end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Self-checking bench for cnn_window_gen: behavioural window model plus per-cycle checker.
module tb_cnn_window_gen;

    localparam int W     = 28;
    localparam int H     = 28;
    localparam int K     = 5;
    localparam int PW    = 8;
    localparam int NP    = W * H;
    localparam int NW    = (W - K + 1) * (H - K + 1);
    localparam int WB    = K * K * PW;
    localparam int LIMIT = 10000;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          START;
    logic [7:0]    PIX_IN;
    logic          PIX_VALID;
    logic          PIX_READY;
    logic [WB-1:0] WIN;
    logic          WIN_VALID;
    logic          WIN_READY;
    logic [4:0]    WX;
    logic [4:0]    WY;
    logic          BUSY;
    logic          FRAME_DONE;

    cnn_window_gen dut (
        .CLK(CLK), .nRST(nRST), .START(START), .PIX_IN(PIX_IN), .PIX_VALID(PIX_VALID),
        .PIX_READY(PIX_READY), .WIN(WIN), .WIN_VALID(WIN_VALID), .WIN_READY(WIN_READY),
        .WX(WX), .WY(WY), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]    wx;
        logic [4:0]    wy;
        logic [WB-1:0] win;
    } win_t;

    win_t       exp_q[$];
    logic [7:0] img [NP];
    int         errors = 0;
    int         checks = 0;
    bit         chk_en = 1'b0;
    int         acc = 0;
    int         win_cnt = 0;
    int         fd_cnt = 0;

    task automatic chk_b(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_n(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [WB-1:0] act, input logic [WB-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int byte_of(input logic [WB-1:0] w, input int n);
        logic [7:0] b;
        b = w[8*n +: 8];
        return int'(b);
    endfunction

    // Build the image and the full ordered list of windows it must produce.
    function automatic void build_model(input bit pattern);
        win_t e;
        exp_q.delete();
        for (int row = 0; row < H; row++) begin
            for (int col = 0; col < W; col++) begin
                img[row*W+col] = pattern ? 8'((row * W + col) % 256) : 8'($urandom);
            end
        end
        for (int wy = 0; wy <= H - K; wy++) begin
            for (int wx = 0; wx <= W - K; wx++) begin
                e.wx  = 5'(wx);
                e.wy  = 5'(wy);
                e.win = '0;
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        e.win[PW*(r*K+c) +: PW] = img[(wy+r)*W + wx + c];
                    end
                end
                exp_q.push_back(e);
            end
        end
    endfunction

    // Per-cycle checker state.
    logic          prev_stall = 1'b0;
    logic          exp_fd = 1'b0;
    logic          exp_load = 1'b0;
    logic [4:0]    ld_wx;
    logic [4:0]    ld_wy;
    logic [WB-1:0] held_win;
    logic [4:0]    held_wx;
    logic [4:0]    held_wy;
    win_t          mon_e;
    int            mon_r;
    int            mon_c;

    always @(negedge CLK) begin
        if (!chk_en) begin
            prev_stall = 1'b0;
            exp_fd     = 1'b0;
            exp_load   = 1'b0;
        end else begin
            chk_b("frame_done", FRAME_DONE, exp_fd);
            if (FRAME_DONE) begin
                fd_cnt++;
                chk_b("busy_after_done", BUSY, 1'b0);
            end
            if (exp_q.size() != 0) chk_b("busy_in_frame", BUSY, 1'b1);
            chk_b("win_valid", WIN_VALID, exp_load | prev_stall);
            if (exp_load) begin
                chk_n("load_wx", int'(WX), int'(ld_wx));
                chk_n("load_wy", int'(WY), int'(ld_wy));
            end
            if (prev_stall) begin
                chk_w("hold_win", WIN, held_win);
                chk_n("hold_wx", int'(WX), int'(held_wx));
                chk_n("hold_wy", int'(WY), int'(held_wy));
            end
            exp_fd   = 1'b0;
            exp_load = 1'b0;
            if (WIN_VALID && WIN_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_window: got WX=%0d WY=%0d expected none", WX, WY);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk_n("win_x", int'(WX), int'(mon_e.wx));
                    chk_n("win_y", int'(WY), int'(mon_e.wy));
                    chk_w("win_data", WIN, mon_e.win);
                    win_cnt++;
                    if (exp_q.size() == 0) exp_fd = 1'b1;
                end
            end
            if (WIN_VALID && !WIN_READY) chk_b("pix_ready_stall", PIX_READY, 1'b0);
            prev_stall = WIN_VALID && !WIN_READY;
            held_win   = WIN;
            held_wx    = WX;
            held_wy    = WY;
            if (PIX_VALID && PIX_READY) begin
                mon_r = acc / W;
                mon_c = acc % W;
                if (mon_r >= K - 1 && mon_c >= K - 1) begin
                    exp_load = 1'b1;
                    ld_wx    = 5'(mon_c - (K - 1));
                    ld_wy    = 5'(mon_r - (K - 1));
                end
                acc++;
            end
        end
    end

    // Mode 0: ramp image, always ready. 1: ramp with a 10-cycle stall at window 30.
    // 2: random image, random pixel gaps, random consumer, stray START pulses.
    task automatic run_frame(input int mode, input bit do_start);
        int idx = 0;
        int cyc = 0;
        int fd0;
        int win0;
        int bp_left = 0;
        bit bp_done = 1'b0;
        if (do_start) begin
            acc = 0;
            @(posedge CLK); #1 START = 1'b1;
            @(posedge CLK); #1 START = 1'b0;
        end
        build_model(mode < 2);
        fd0  = fd_cnt;
        win0 = win_cnt;
        while ((idx < NP || fd_cnt == fd0) && cyc < LIMIT) begin
            @(posedge CLK); #1;
            cyc++;
            PIX_VALID = (idx < NP) && (mode < 2 || $urandom_range(0, 3) != 0);
            PIX_IN    = (idx < NP) ? img[idx] : 8'($urandom);
            START     = (mode == 2) && (idx > 0) && (idx < NP) && ($urandom_range(0, 39) == 0);
            if (mode == 1 && !bp_done && (win_cnt - win0) == 30) begin
                bp_left = 10;
                bp_done = 1'b1;
            end
            if (mode == 2) begin
                WIN_READY = ($urandom_range(0, 2) != 0);
            end else begin
                WIN_READY = (bp_left == 0);
                if (bp_left > 0) bp_left--;
            end
            @(negedge CLK);
            if (PIX_VALID && PIX_READY) idx++;
        end
        @(posedge CLK); #1;
        PIX_VALID = 1'b0;
        START     = 1'b0;
        WIN_READY = 1'b1;
        chk_n("frame_finished", fd_cnt - fd0, 1);
        chk_n("window_count", win_cnt - win0, NW);
        chk_n("model_drained", exp_q.size(), 0);
    endtask

    initial begin
        nRST      = 1'b0;
        START     = 1'b0;
        PIX_VALID = 1'b0;
        PIX_IN    = 8'd0;
        WIN_READY = 1'b1;
        #12;
        chk_b("rst_pix_ready", PIX_READY, 1'b0);
        chk_b("rst_win_valid", WIN_VALID, 1'b0);
        chk_b("rst_busy", BUSY, 1'b0);
        chk_w("rst_win", WIN, '0);
        @(negedge CLK) nRST = 1'b1;

        // Pin the model against hand-computed values for the ramp image.
        build_model(1'b1);
        chk_n("model_first_wx", int'(exp_q[0].wx), 0);
        chk_n("model_first_wy", int'(exp_q[0].wy), 0);
        chk_n("model_first_b0", byte_of(exp_q[0].win, 0), 0);
        chk_n("model_first_b24", byte_of(exp_q[0].win, 24), 116);
        chk_n("model_last_wx", int'(exp_q[NW-1].wx), 23);
        chk_n("model_last_wy", int'(exp_q[NW-1].wy), 23);
        chk_n("model_last_b0", byte_of(exp_q[NW-1].win, 0), 155);
        chk_n("model_k53_wx", int'(exp_q[53].wx), 5);
        chk_n("model_k53_wy", int'(exp_q[53].wy), 2);
        chk_n("model_k53_b6", byte_of(exp_q[53].win, 6), 90);
        exp_q.delete();

        // Abort a frame with an asynchronous reset between clock edges.
        @(posedge CLK); #1 START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge CLK); #1;
            PIX_VALID = 1'b1;
            PIX_IN    = 8'(i * 7);
            @(negedge CLK);
        end
        chk_b("pre_reset_busy", BUSY, 1'b1);
        #2 nRST = 1'b0;
        #1;
        chk_b("async_pix_ready", PIX_READY, 1'b0);
        chk_b("async_win_valid", WIN_VALID, 1'b0);
        chk_b("async_busy", BUSY, 1'b0);
        chk_b("async_frame_done", FRAME_DONE, 1'b0);
        chk_n("async_wx", int'(WX), 0);
        chk_n("async_wy", int'(WY), 0);
        chk_w("async_win", WIN, '0);
        PIX_VALID = 1'b0;
        @(negedge CLK) nRST = 1'b1;
        chk_en = 1'b1;

        run_frame(0, 1'b1);
        run_frame(1, 1'b1);
        for (int f = 0; f < 3; f++) run_frame(2, 1'b1);

        // START in IDLE with no pixels: busy, but nothing emitted.
        acc = 0;
        @(posedge CLK); #1 START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            chk_b("idle_start_busy", BUSY, 1'b1);
            chk_b("idle_start_no_win", WIN_VALID, 1'b0);
        end
        run_frame(2, 1'b0);

        repeat (3) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "watchdog");
    end

endmodule
